gerenciador_de_posicionamento: RTL and testbench

- Builds the hidden fleet map (mapa0..mapa4) that the attack manager later reads.
- The player steps through a fixed list of ships. For each ship they choose column, row and orientation, then confirm.
- The block checks bounds and overlap, writes valid ships into the map and reports accept/reject on the status LEDs.
- When every ship has been placed it raises pronto and freezes the map.

---
 rtl/gerenciador_de_posicionamento.sv | 208 ++++++++++++++++++++
 tb/tb_gerenciador_de_posicionamento.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_de_posicionamento.sv
// ---------------------------------------------------------------------------
// gerenciador_de_posicionamento
//
// Builds the hidden fleet map. The player steps through a fixed list of
// ships, choosing column, row and orientation for each one and confirming.
// Every confirm is checked for bounds and overlap. A valid ship is written
// into the map and lights LED_G. An invalid one lights LED_R and leaves the
// map untouched. Once the last ship is placed, pronto rises and the map is
// frozen until reiniciar or reset_n.
//
// Optional build macro: PROIBIR_ADJACENCIA_EN
//   When defined, a ship is also rejected if any existing ship cell is
//   orthogonally adjacent to one of its cells.
//
// Ports:
//   clock         system clock
//   reset_n       asynchronous active-low reset
//   coordColuna   anchor column (0..4 valid)
//   coordLinha    anchor row (0..6 valid)
//   orientacao    0 = horizontal (+column), 1 = vertical (+row)
//   confirmar     confirm level; its rising edge is detected internally
//   reiniciar     synchronous clear of the map and the ship counter
//   mapa0..4      map columns 0..4, bit n = row n, 1 = ship cell
//   preview0..4   map OR current candidate (candidate hidden once pronto)
//   navio_atual   index of the ship being placed
//   pronto        all ships placed
//   LED_R, LED_G  result of the last confirm (reject / accept)
// ---------------------------------------------------------------------------
module gerenciador_de_posicionamento #(
   parameter int NUM_NAVIOS = 3,
   parameter int TAM_NAVIO0 = 3,
   parameter int TAM_NAVIO1 = 2,
   parameter int TAM_NAVIO2 = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [2:0] coordColuna,
   input  logic [2:0] coordLinha,
   input  logic       orientacao,
   input  logic       confirmar,
   input  logic       reiniciar,
   output logic [6:0] mapa0,
   output logic [6:0] mapa1,
   output logic [6:0] mapa2,
   output logic [6:0] mapa3,
   output logic [6:0] mapa4,
   output logic [6:0] preview0,
   output logic [6:0] preview1,
   output logic [6:0] preview2,
   output logic [6:0] preview3,
   output logic [6:0] preview4,
   output logic [1:0] navio_atual,
   output logic       pronto,
   output logic       LED_R,
   output logic       LED_G
);

   typedef enum logic {COLOCANDO = 1'b0, PRONTO = 1'b1} estado_t;

   estado_t    r_estado, w_proximo;
   logic       r_conf_q;
   logic [6:0] r_mapa [5];
   logic [1:0] r_navio;
   logic       r_led_r, r_led_g;

   logic       w_conf_ev;
   logic [3:0] w_tam, w_col, w_lin, w_fim;
   logic [6:0] w_cand [5];
   logic       w_dentro, w_conflito, w_valido, w_ultimo;
   logic       w_aceita, w_rejeita, w_mostra_cand;

   assign w_conf_ev = confirmar & ~r_conf_q;

   // 4-bit coordinates so anchor + length - 1 can never wrap
   assign w_col = {1'b0, coordColuna};
   assign w_lin = {1'b0, coordLinha};

   always_comb begin
      w_tam = 4'd1;
      case (r_navio)
         2'd0:    w_tam = 4'(TAM_NAVIO0);
         2'd1:    w_tam = 4'(TAM_NAVIO1);
         2'd2:    w_tam = 4'(TAM_NAVIO2);
         default: w_tam = 4'd1;
      endcase
   end

   assign w_fim    = (orientacao ? w_lin : w_col) + w_tam - 4'd1;
   assign w_dentro = (w_col < 4'd5) && (w_lin < 4'd7) &&
                     (orientacao ? (w_fim <= 4'd6) : (w_fim <= 4'd4));
   assign w_ultimo = (r_navio == 2'(NUM_NAVIOS - 1));

   // Candidate mask: only in-range cells are enumerated, so cells falling
   // off the board are simply dropped.
   always_comb begin
      for (int c = 0; c < 5; c++) begin
         w_cand[c] = '0;
         for (int r = 0; r < 7; r++) begin
            if (!orientacao)
               w_cand[c][r] = (4'(r) == w_lin) && (4'(c) >= w_col) &&
                              (4'(c) < w_col + w_tam);
            else
               w_cand[c][r] = (4'(c) == w_col) && (4'(r) >= w_lin) &&
                              (4'(r) < w_lin + w_tam);
         end
      end
   end

`ifdef PROIBIR_ADJACENCIA_EN
   // Candidate dilated by one cell in each orthogonal direction; it covers
   // the candidate itself, so overlap is rejected as well. Zero-padded
   // neighbour columns clip the dilation at the left/right edges, and the
   // 7-bit shifts clip it at the top/bottom.
   logic [6:0] w_cand_ext [7];
   logic [6:0] w_adj [5];

   always_comb begin
      w_cand_ext[0] = '0;
      w_cand_ext[6] = '0;
      for (int c = 0; c < 5; c++) w_cand_ext[c+1] = w_cand[c];
      w_conflito = 1'b0;
      for (int c = 0; c < 5; c++) begin
         w_adj[c] = w_cand[c] | (w_cand[c] << 1) | (w_cand[c] >> 1) |
                    w_cand_ext[c] | w_cand_ext[c+2];
         w_conflito = w_conflito | (|(w_adj[c] & r_mapa[c]));
      end
   end
`else
   always_comb begin
      w_conflito = 1'b0;
      for (int c = 0; c < 5; c++)
         w_conflito = w_conflito | (|(w_cand[c] & r_mapa[c]));
   end
`endif

   assign w_valido = w_dentro & ~w_conflito;

   // FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_estado <= COLOCANDO;
      else          r_estado <= w_proximo;
   end

   // FSM: next state
   always_comb begin
      w_proximo = r_estado;
      if (reiniciar)
         w_proximo = COLOCANDO;
      else if (r_estado == COLOCANDO && w_conf_ev && w_valido && w_ultimo)
         w_proximo = PRONTO;
   end

   // FSM: outputs (reiniciar beats a coincident confirm)
   always_comb begin
      w_aceita      = 1'b0;
      w_rejeita     = 1'b0;
      w_mostra_cand = (r_estado == COLOCANDO);
      if (!reiniciar && r_estado == COLOCANDO && w_conf_ev) begin
         w_aceita  = w_valido;
         w_rejeita = ~w_valido;
      end
   end

   // Map, ship counter, LEDs and confirm-edge register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_conf_q <= 1'b0;
         r_navio  <= '0;
         r_led_r  <= 1'b0;
         r_led_g  <= 1'b0;
         for (int c = 0; c < 5; c++) r_mapa[c] <= '0;
      end else begin
         r_conf_q <= confirmar;
         if (reiniciar) begin
            r_navio <= '0;
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
            for (int c = 0; c < 5; c++) r_mapa[c] <= '0;
         end else if (w_aceita) begin
            for (int c = 0; c < 5; c++) r_mapa[c] <= r_mapa[c] | w_cand[c];
            r_led_g <= 1'b1;
            r_led_r <= 1'b0;
            if (!w_ultimo) r_navio <= r_navio + 2'd1;
         end else if (w_rejeita) begin
            r_led_r <= 1'b1;
            r_led_g <= 1'b0;
         end
      end
   end

   assign mapa0 = r_mapa[0];
   assign mapa1 = r_mapa[1];
   assign mapa2 = r_mapa[2];
   assign mapa3 = r_mapa[3];
   assign mapa4 = r_mapa[4];

   assign preview0 = r_mapa[0] | (w_mostra_cand ? w_cand[0] : 7'd0);
   assign preview1 = r_mapa[1] | (w_mostra_cand ? w_cand[1] : 7'd0);
   assign preview2 = r_mapa[2] | (w_mostra_cand ? w_cand[2] : 7'd0);
   assign preview3 = r_mapa[3] | (w_mostra_cand ? w_cand[3] : 7'd0);
   assign preview4 = r_mapa[4] | (w_mostra_cand ? w_cand[4] : 7'd0);

   assign navio_atual = r_navio;
   assign pronto      = (r_estado == PRONTO);
   assign LED_R       = r_led_r;
   assign LED_G       = r_led_g;

endmodule

// File: tb/tb_gerenciador_de_posicionamento.sv
// Directed bench for gerenciador_de_posicionamento (default parameters:
// three ships of length 3, 2 and 1). Maps are compared packed as
// {mapa4, mapa3, mapa2, mapa1, mapa0}.
module tb_gerenciador_de_posicionamento;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [2:0] coordColuna;
   logic [2:0] coordLinha;
   logic       orientacao;
   logic       confirmar;
   logic       reiniciar;
   logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
   logic [6:0] preview0, preview1, preview2, preview3, preview4;
   logic [1:0] navio_atual;
   logic       pronto;
   logic       LED_R, LED_G;

   int total = 0;
   int bad   = 0;

   logic [34:0] w_mapa, w_prev;
   assign w_mapa = {mapa4, mapa3, mapa2, mapa1, mapa0};
   assign w_prev = {preview4, preview3, preview2, preview1, preview0};

   gerenciador_de_posicionamento dut (
      .clock(clock), .reset_n(reset_n),
      .coordColuna(coordColuna), .coordLinha(coordLinha),
      .orientacao(orientacao), .confirmar(confirmar), .reiniciar(reiniciar),
      .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
      .preview0(preview0), .preview1(preview1), .preview2(preview2),
      .preview3(preview3), .preview4(preview4),
      .navio_atual(navio_atual), .pronto(pronto), .LED_R(LED_R), .LED_G(LED_G)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_coord(input logic [2:0] col, input logic [2:0] lin, input logic ori);
      coordColuna = col;
      coordLinha  = lin;
      orientacao  = ori;
   endtask

   // Raise confirmar with the given placement and step one edge;
   // results are checked right after that edge, then confirm_off drops it.
   task automatic confirm_on(input logic [2:0] col, input logic [2:0] lin, input logic ori);
      set_coord(col, lin, ori);
      confirmar = 1'b1;
      tick();
   endtask

   task automatic confirm_off();
      confirmar = 1'b0;
      tick();
   endtask

   // {status LEDs R,G, pronto, navio_atual}
   function automatic logic [4:0] st(input logic r, input logic g, input logic p, input logic [1:0] n);
      return {r, g, p, n};
   endfunction

   logic [4:0]  w_st;
   assign w_st = {LED_R, LED_G, pronto, navio_atual};

   localparam logic [34:0] M_SHIP0   = {7'd0, 7'd0, 7'b0000001, 7'b0000001, 7'b0000001};
   localparam logic [34:0] M_SHIP01  = {7'b1100000, 7'd0, 7'b0000001, 7'b0000001, 7'b0000001};
   localparam logic [34:0] M_SHIP012 = {7'b1100000, 7'd0, 7'b0001001, 7'b0000001, 7'b0000001};

   initial begin
      reset_n   = 1'b0;
      confirmar = 1'b0;
      reiniciar = 1'b0;
      set_coord(3'd0, 3'd0, 1'b0);
      #12;
      check("reset_map", w_mapa, 35'd0);
      check("reset_status", w_st, st(0, 0, 0, 2'd0));
      reset_n = 1'b1;
      tick();

      // Preview of ship 0 at (0,0) horizontal before confirming
      #1;
      check("preview_ship0", w_prev, M_SHIP0);

      // Case 1
      confirm_on(3'd0, 3'd0, 1'b0);
      check("c1_map", w_mapa, M_SHIP0);
      check("c1_status", w_st, st(0, 1, 0, 2'd1));
      confirm_off();

      // Case 2: off the right edge, preview drops the out-of-range cell
      set_coord(3'd4, 3'd0, 1'b0);
      #1;
      check("c2_preview_clip", w_prev, {7'b0000001, 7'd0, 7'b0000001, 7'b0000001, 7'b0000001});
      confirm_on(3'd4, 3'd0, 1'b0);
      check("c2_rej_map", w_mapa, M_SHIP0);
      check("c2_rej_status", w_st, st(1, 0, 0, 2'd1));
      confirm_off();
      confirm_on(3'd4, 3'd5, 1'b1);
      check("c2_acc_map", w_mapa, M_SHIP01);
      check("c2_acc_status", w_st, st(0, 1, 0, 2'd2));
      confirm_off();

      // Case 3: overlap, then last ship, then ignored confirm
      confirm_on(3'd1, 3'd0, 1'b0);
      check("c3_overlap_map", w_mapa, M_SHIP01);
      check("c3_overlap_status", w_st, st(1, 0, 0, 2'd2));
      confirm_off();
      confirm_on(3'd2, 3'd3, 1'b0);
      check("c3_last_map", w_mapa, M_SHIP012);
      check("c3_last_status", w_st, st(0, 1, 1, 2'd2));
      confirm_off();
      set_coord(3'd3, 3'd3, 1'b0);
      #1;
      check("c3_pronto_preview", w_prev, M_SHIP012);
      confirm_on(3'd3, 3'd3, 1'b0);
      check("c3_frozen_map", w_mapa, M_SHIP012);
      check("c3_frozen_status", w_st, st(0, 1, 1, 2'd2));
      confirm_off();

      // Case 4: reiniciar, then hold confirmar for 5 cycles
      reiniciar = 1'b1;
      tick();
      reiniciar = 1'b0;
      check("c4_clear_map", w_mapa, 35'd0);
      check("c4_clear_status", w_st, st(0, 0, 0, 2'd0));
      set_coord(3'd0, 3'd0, 1'b0);
      confirmar = 1'b1;
      repeat (5) tick();
      check("c4_hold_map", w_mapa, M_SHIP0);
      check("c4_hold_status", w_st, st(0, 1, 0, 2'd1));
      confirm_off();

      // Case 5a: asynchronous reset mid-cycle
      confirm_on(3'd4, 3'd5, 1'b1);
      check("c5_two_ships", w_mapa, M_SHIP01);
      confirm_off();
      #2 reset_n = 1'b0;
      #1;
      check("c5_async_map", w_mapa, 35'd0);
      check("c5_async_status", w_st, st(0, 0, 0, 2'd0));
      reset_n = 1'b1;
      tick();

      // Case 5b: reiniciar coincident with a valid confirm
      confirm_on(3'd0, 3'd0, 1'b0);
      confirm_off();
      confirm_on(3'd4, 3'd5, 1'b1);
      confirm_off();
      check("c5b_setup_status", w_st, st(0, 1, 0, 2'd2));
      set_coord(3'd2, 3'd3, 1'b0);
      reiniciar = 1'b1;
      confirmar = 1'b1;
      tick();
      check("c5b_map", w_mapa, 35'd0);
      check("c5b_status", w_st, st(0, 0, 0, 2'd0));
      reiniciar = 1'b0;
      confirm_off();

      // Case 6: ship touching ship 0 from below
      confirm_on(3'd0, 3'd0, 1'b0);
      confirm_off();
      confirm_on(3'd0, 3'd1, 1'b0);
`ifdef PROIBIR_ADJACENCIA_EN
      check("c6_adj_map", w_mapa, M_SHIP0);
      check("c6_adj_status", w_st, st(1, 0, 0, 2'd1));
`else
      check("c6_adj_map", w_mapa, {7'd0, 7'd0, 7'b0000001, 7'b0000011, 7'b0000011});
      check("c6_adj_status", w_st, st(0, 1, 0, 2'd2));
`endif
      confirm_off();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
